// File: rtl/mac_pkg.sv
// Shared types and constants for the data-memory access controller.
package mac_pkg;
   localparam int WORD_BYTES = 4;
   localparam int BYTE_W     = 8;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } mac_state_e;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response handshake and data-memory port of mem_access_ctrl.
interface mem_access_ctrl_if #(parameter int N = 32);
   logic         req_valid;
   logic         req_ready;
   logic         req_we;
   logic         req_byte;
   logic         req_signed;
   logic [N-1:0] req_addr;
   logic [N-1:0] req_wdata;
   logic [N-1:0] mem_addr;
   logic [N-1:0] mem_wdata;
   logic         mem_re;
   logic         mem_we;
   logic         mem_byte;
   logic [N-1:0] mem_rdata;
   logic         resp_valid;
   logic         resp_ready;
   logic [N-1:0] resp_data;
   logic         resp_err;

   // slave: the controller; master: pipeline plus memory around it
   modport slave (
      input  req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
      input  mem_rdata, resp_ready,
      output req_ready, mem_addr, mem_wdata, mem_re, mem_we, mem_byte,
      output resp_valid, resp_data, resp_err
   );

   modport master (
      output req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
      output mem_rdata, resp_ready,
      input  req_ready, mem_addr, mem_wdata, mem_re, mem_we, mem_byte,
      input  resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/mac_load_align.sv
// Load-data select/extension of raw memory read data (byte vs word).
// Sign extension of byte loads exists only when MAC_SIGNEXT_EN is defined.
module mac_load_align
   import mac_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] rdata_i,
   input  logic         byte_i,
   input  logic         signed_i,
   output logic [N-1:0] data_o
);

   // upper bits of a byte read are undefined at the memory; never pass them on
   always_comb begin
      data_o = rdata_i;
      if (byte_i) begin
`ifdef MAC_SIGNEXT_EN
         data_o = {{(N-BYTE_W){signed_i & rdata_i[BYTE_W-1]}}, rdata_i[BYTE_W-1:0]};
`else
         data_o = {{(N-BYTE_W){1'b0}}, rdata_i[BYTE_W-1:0]};
`endif
      end
   end

`ifndef MAC_SIGNEXT_EN
   logic unused_signed;
   assign unused_signed = signed_i;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller between pipeline and data memory.
// Byte-load sign extension enabled by defining MAC_SIGNEXT_EN.
module mem_access_ctrl
   import mac_pkg::*;
#(
   parameter int N          = 32,
   parameter int ADDR_WIDTH = 19,
   parameter int MEM_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   mem_access_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(MEM_LAT - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD =
      {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(WORD_BYTES - 1);

   mac_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     addr_q, addr_d;
   logic [N-1:0]     wdata_q, wdata_d;
   logic             we_q, we_d;
   logic             byte_q, byte_d;
   logic             signed_q, signed_d;
   logic [N-1:0]     resp_data_q, resp_data_d;
   logic             resp_err_q, resp_err_d;

   logic [N-1:0]     addr_hi;
   logic             req_err;
   logic [N-1:0]     load_data;

   // out of range, or a word whose last byte falls past the implemented space
   assign addr_hi = bus.req_addr >> ADDR_WIDTH;
   assign req_err = (|addr_hi) ||
                    (!bus.req_byte && (bus.req_addr[ADDR_WIDTH-1:0] > LAST_WORD));

   mac_load_align #(.N(N)) u_align (
      .rdata_i  (bus.mem_rdata),
      .byte_i   (byte_q),
      .signed_i (signed_q),
      .data_o   (load_data)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      byte_d      = byte_q;
      signed_d    = signed_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d      = bus.req_addr;
               wdata_d     = bus.req_wdata;
               we_d        = bus.req_we;
               byte_d      = bus.req_byte;
               signed_d    = bus.req_signed;
               resp_data_d = '0;
               resp_err_d  = req_err;
               state_d     = req_err ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d       = '0;
               resp_data_d = we_q ? '0 : load_data;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         byte_q      <= 1'b0;
         signed_q    <= 1'b0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         byte_q      <= byte_d;
         signed_q    <= signed_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   // address/data come straight from the latched request, so they stay put
   // from ISSUE through WAIT; enables are a single ISSUE-cycle pulse
   assign bus.req_ready  = (state_q == IDLE);
   assign bus.mem_re     = (state_q == ISSUE) && !we_q;
   assign bus.mem_we     = (state_q == ISSUE) &&  we_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.mem_byte   = byte_q;
   assign bus.resp_valid = (state_q == DONE);
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: directed cases plus random loads/stores against a
// byte-array reference model and a latency-accurate memory model.
module tb_mem_access_ctrl;
   localparam int N   = 32;
   localparam int AW  = 19;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_access_ctrl_if #(.N(N)) bus ();

   mem_access_ctrl #(.N(N), .ADDR_WIDTH(AW), .MEM_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- memory model (drives mem_rdata) ----------------
   logic [7:0]  mem     [logic [31:0]];
   logic [7:0]  ref_mem [logic [31:0]];
   int          rd_cnt = 0;
   logic [31:0] rd_val, junk;
   int          re_cnt = 0, we_cnt = 0;
   logic [31:0] p_addr, p_wdata;
   logic        p_byte;
   logic        pulse, prev_pulse = 1'b0, proto_bad = 1'b0;

   function automatic logic [7:0] mem_rd8(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   function automatic logic [7:0] ref_rd8(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   // data is only valid during the last cycle before the controller must sample it
   always @(negedge clk) begin
      pulse = bus.mem_re | bus.mem_we;
      if ((pulse && prev_pulse) || (bus.mem_re && bus.mem_we)) proto_bad = 1'b1;
      prev_pulse = pulse;
      junk = $urandom;
      if (bus.mem_we) begin
         we_cnt++;
         p_addr = bus.mem_addr; p_wdata = bus.mem_wdata; p_byte = bus.mem_byte;
         if (bus.mem_byte) mem[bus.mem_addr] = bus.mem_wdata[7:0];
         else for (int i = 0; i < 4; i++) mem[bus.mem_addr + i] = bus.mem_wdata[8*i +: 8];
      end
      if (bus.mem_re) begin
         re_cnt++;
         p_addr = bus.mem_addr; p_byte = bus.mem_byte;
         if (bus.mem_byte) rd_val = {junk[31:8], mem_rd8(bus.mem_addr)};
         else for (int i = 0; i < 4; i++) rd_val[8*i +: 8] = mem_rd8(bus.mem_addr + i);
         rd_cnt = LAT;
         bus.mem_rdata = $urandom;
      end else if (rd_cnt > 0) begin
         rd_cnt--;
         bus.mem_rdata = (rd_cnt == 0) ? rd_val : $urandom;
      end else begin
         bus.mem_rdata = $urandom;
      end
   end

   // ---------------- reference model + one transaction ----------------
   task automatic xact(input logic we, input logic b, input logic s,
                       input logic [31:0] a, input logic [31:0] wd, input int hold);
      logic        e;
      logic [31:0] ed;
      logic [7:0]  v;
      longint      lim;
      int          j, re0, we0;
      lim = longint'(1) << AW;
      e   = (longint'(a) >= lim) || (!b && (longint'(a) + 4 > lim));
      ed  = '0;
      if (!e && we) begin
         if (b) ref_mem[a] = wd[7:0];
         else for (int i = 0; i < 4; i++) ref_mem[a + i] = wd[8*i +: 8];
      end else if (!e) begin
         if (b) begin
            v  = ref_rd8(a);
`ifdef MAC_SIGNEXT_EN
            ed = (s && v[7]) ? {24'hFFFFFF, v} : {24'h0, v};
`else
            ed = {24'h0, v};
`endif
         end else begin
            for (int i = 0; i < 4; i++) ed[8*i +: 8] = ref_rd8(a + i);
         end
      end

      j = 0;
      while (!bus.req_ready && j < 50) begin @(negedge clk); j++; end
      chk("req_ready_before", bus.req_ready, 1'b1);
      bus.req_we = we; bus.req_byte = b; bus.req_signed = s;
      bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
      re0 = re_cnt; we0 = we_cnt;
      @(posedge clk); @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_we = 1'($urandom);
      j = 1;
      while (!bus.resp_valid && j < 100) begin @(negedge clk); j++; end
      chk("latency", j, e ? 1 : 2 + LAT);
      chk("resp_err", bus.resp_err, e);
      chk("resp_data", bus.resp_data, ed);
      chk("mem_re_pulses", re_cnt - re0, (!e && !we) ? 1 : 0);
      chk("mem_we_pulses", we_cnt - we0, (!e &&  we) ? 1 : 0);
      if (!e) begin
         chk("mem_addr", p_addr, a);
         chk("mem_byte", p_byte, b);
         if (we) chk("mem_wdata", p_wdata, wd);
      end
      // back-pressure: a pending request must be ignored while not ready
      for (int k = 0; k < hold; k++) begin
         bus.req_valid = 1'b1; bus.req_addr = $urandom; bus.req_we = 1'($urandom);
         @(negedge clk);
         chk("hold_valid", bus.resp_valid, 1'b1);
         chk("hold_data", bus.resp_data, ed);
         chk("hold_err", bus.resp_err, e);
         chk("hold_req_ready", bus.req_ready, 1'b0);
      end
      bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.resp_ready = 1'b0;
      chk("idle_after_hs", bus.req_ready, 1'b1);
      chk("valid_dropped", bus.resp_valid, 1'b0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_req_ready"},  bus.req_ready,  1'b1);
      chk({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
      chk({tag, "_resp_err"},   bus.resp_err,   1'b0);
      chk({tag, "_resp_data"},  bus.resp_data,  32'h0);
      chk({tag, "_mem_re"},     bus.mem_re,     1'b0);
      chk({tag, "_mem_we"},     bus.mem_we,     1'b0);
      chk({tag, "_mem_addr"},   bus.mem_addr,   32'h0);
      chk({tag, "_mem_wdata"},  bus.mem_wdata,  32'h0);
      chk({tag, "_mem_byte"},   bus.mem_byte,   1'b0);
   endtask

   initial begin
      logic [31:0] a;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_byte = 1'b0; bus.req_signed = 1'b0;
      bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_state("reset");
      rst = 1'b0;
      @(negedge clk);

      // word store then load
      xact(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 0);
      xact(1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 0);
      // byte store/load, unsigned and signed
      xact(1'b1, 1'b1, 1'b0, 32'h0000_2001, 32'h0000_00F0, 0);
      xact(1'b0, 1'b1, 1'b0, 32'h0000_2001, 32'h0, 0);
      xact(1'b0, 1'b1, 1'b1, 32'h0000_2001, 32'h0, 0);
      // address range boundaries
      xact(1'b0, 1'b0, 1'b0, 32'h0007_FFFE, 32'h0, 0);
      xact(1'b0, 1'b0, 1'b0, 32'h0008_0000, 32'h0, 0);
      xact(1'b1, 1'b0, 1'b0, 32'h0007_FFFC, 32'h1234_5678, 0);
      xact(1'b0, 1'b0, 1'b0, 32'h0007_FFFC, 32'h0, 0);
      xact(1'b0, 1'b1, 1'b0, 32'h0007_FFFF, 32'h0, 0);
      xact(1'b1, 1'b1, 1'b0, 32'h0008_0000, 32'hAA, 2);
      // long back-pressure
      xact(1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 5);

      // reset while waiting on memory
      bus.req_we = 1'b0; bus.req_byte = 1'b0; bus.req_addr = 32'h0000_1000; bus.req_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      chk_reset_state("midrst");
      xact(1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 0);

      // random mix
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 3))
            0: a = 32'h0000_1000 + $urandom_range(0, 31);
            1: a = 32'h0007_FFF8 + $urandom_range(0, 7);
            2: a = 32'h0008_0000 + $urandom_range(0, 3);
            default: a = $urandom;
         endcase
         xact(1'($urandom), 1'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 3));
      end

      chk("enable_pulse_protocol", proto_bad, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter N, default 32: data and address width.
REQ-002 Parameter ADDR_WIDTH, default 19: implemented byte-address bits of data memory.
REQ-003 Parameter MEM_LAT, default 1, range 1..15: cycles from enable pulse to valid mem_rdata.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  pipeline presents an access.
REQ-007 req_ready  out  1  block accepts the request this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_byte  in  1  1 = byte access, 0 = word (4-byte, little-endian).
REQ-010 req_signed  in  1  byte load sign-extends (used only with MAC_SIGNEXT_EN).
REQ-011 req_addr  in  N  byte address.
REQ-012 req_wdata  in  N  store data.
REQ-013 mem_addr, mem_wdata  out  N  address/data to data memory.
REQ-014 mem_re, mem_we, mem_byte  out  1  memory read/write enables and byte select.
REQ-015 mem_rdata  in  N  memory read data (upper 24 bits undefined on byte reads).
REQ-016 resp_valid  out  1; resp_ready  in  1; resp_data  out  N; resp_err  out  1  writeback handshake.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, DONE; req_ready=1 only in IDLE.
REQ-018 Accept on req_valid&&req_ready; latch all req_* fields; go to ISSUE.
REQ-019 Error check at accept: any req_addr bit above ADDR_WIDTH-1 set, or word access with low ADDR_WIDTH bits > 2^ADDR_WIDTH-4 -> resp_err=1, resp_data=0, go directly to DONE, no memory enable.
REQ-020 ISSUE: mem_addr/mem_wdata/mem_byte driven from latched fields; exactly one of mem_re/mem_we high for this single cycle; next WAIT.
REQ-021 mem_re/mem_we low in every other state; at least one low cycle between consecutive pulses (memory is edge-triggered).
REQ-022 mem_addr/mem_wdata/mem_byte held stable from ISSUE through end of WAIT.
REQ-023 WAIT: counter runs MEM_LAT cycles; on last WAIT cycle capture resp_data; go DONE.
REQ-024 Load capture: word -> mem_rdata; byte -> {24'h0, mem_rdata[7:0]}; never propagate X/Z upper bits. Store -> resp_data=0.
REQ-025 DONE: resp_valid=1, resp_data/resp_err stable until resp_ready; on resp_valid&&resp_ready -> IDLE.
REQ-026 Latency: accept at edge T -> resp_valid high from cycle T+2+MEM_LAT; minimum initiation interval 3+MEM_LAT cycles.
REQ-027 req_valid while not ready: ignored, no state change; req_* may change freely.

Reset
REQ-028 rst: state IDLE, counter 0, req_ready=1 (combinational from state), resp_valid=0, resp_err=0, resp_data=0, mem_re=mem_we=0, mem_addr=mem_wdata=0, mem_byte=0.
REQ-029 rst mid-operation (any state) takes effect at that edge; an in-flight response is discarded; memory contents are not this block's concern.

Configuration
REQ-030 Macro MAC_SIGNEXT_EN defined: byte load with req_signed=1 returns {{24{mem_rdata[7]}}, mem_rdata[7:0]}.
REQ-031 MAC_SIGNEXT_EN undefined: req_signed ignored; all byte loads zero-extend.

Structure
REQ-032 Package mac_pkg holds state enum (IDLE/ISSUE/WAIT/DONE) and constant WORD_BYTES=4.
REQ-033 Sub-module mac_load_align: combinational byte/word select and extension of mem_rdata; the FSM and counter stay in mem_access_ctrl.

Verification
REQ-034 Store word 0x1000 data 0xDEADBEEF, then load word 0x1000 -> one-cycle mem_we then mem_re pulses; resp_data=0xDEADBEEF, resp_err=0.
REQ-035 Store byte 0x2001 data 0x000000F0, load byte -> 0x000000F0; with MAC_SIGNEXT_EN and req_signed=1 -> 0xFFFFFFF0.
REQ-036 Load word addr 0x0007FFFE or 0x00080000 -> resp_err=1, resp_data=0, mem_re never asserted.
REQ-037 MEM_LAT=3, resp_ready held low 5 cycles -> resp_valid from T+5, data stable, req_ready=0 until handshake.
REQ-038 rst asserted in WAIT -> next cycle IDLE, resp_valid=0, mem_re=mem_we=0; following load completes normally.
